// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller around a single 1-bit full adder

// One-bit full adder cell; the controller time-multiplexes a single instance of it.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  sum_sr;
    logic              carry;
    logic              fa_sum;
    logic              fa_carry;
    logic              last_bit;

    // The counter holds the index of the bit being processed, so it reaches
    // WIDTH-1 on the final RUN edge without ever wrapping before the decision.
    assign last_bit = (cnt == CW'(WIDTH - 1));

    fa u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, run WIDTH bit-steps, hold in DONE until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid)  state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (i_ready)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded purely from the state.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (state)
            IDLE:    o_ready = 1'b1;
            RUN:     o_busy  = 1'b1;
            DONE:    o_valid = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

    // Datapath: capture operands, shift one bit per RUN edge, publish the result on the last bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            o_sum  <= '0;
            o_cout <= 1'b0;
            o_ovf  <= 1'b0;
        end else begin
            if (state == IDLE && i_valid) begin
                a_sr  <= i_a;
                b_sr  <= i_b;
                carry <= i_cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                carry  <= fa_carry;
                cnt    <= cnt + 1'b1;
                if (last_bit) begin
                    // carry still holds the carry into the MSB here.
                    o_sum  <= {fa_sum, sum_sr[WIDTH-1:1]};
                    o_cout <= fa_carry;
                    o_ovf  <= carry ^ fa_carry;
                end
            end
        end
    end

endmodule
